// File: rtl/game_pkg.sv
// Shared types for the game-progression controller: status codes, state encoding and width helpers.
package game_pkg;

    localparam int LIVES_W = 4;

    typedef enum logic [2:0] {
        GS_PLAYING   = 3'd0,
        GS_WIN_LEVEL = 3'd1,
        GS_WIN_WORLD = 3'd2,
        GS_WIN_GAME  = 3'd3,
        GS_GAME_OVER = 3'd4,
        GS_LIFE_LOST = 3'd5,
        GS_IDLE      = 3'd6
    } game_status_t;

    // Encoded to match the status codes so the output decode is trivial.
    typedef enum logic [2:0] {
        ST_PLAY      = 3'd0,
        ST_WIN_LEVEL = 3'd1,
        ST_WIN_WORLD = 3'd2,
        ST_WIN_GAME  = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_LIFE_LOST = 3'd5,
        ST_IDLE      = 3'd6
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_banner(input state_t s);
        return (s == ST_WIN_LEVEL) || (s == ST_WIN_WORLD) || (s == ST_LIFE_LOST);
    endfunction

    function automatic game_status_t state_to_status(input state_t s);
        game_status_t gs;
        case (s)
            ST_PLAY:      gs = GS_PLAYING;
            ST_WIN_LEVEL: gs = GS_WIN_LEVEL;
            ST_WIN_WORLD: gs = GS_WIN_WORLD;
            ST_WIN_GAME:  gs = GS_WIN_GAME;
            ST_GAME_OVER: gs = GS_GAME_OVER;
            ST_LIFE_LOST: gs = GS_LIFE_LOST;
            default:      gs = GS_IDLE;
        endcase
        return gs;
    endfunction

endpackage

// File: rtl/game_progress_fsm_banner_timer.sv
// Down-counter that loads CYCLES-1 on load and reports done once it reaches zero.
// Also reused by the HUD blink logic, so it carries no game-specific knowledge.
module banner_timer
    import game_pkg::*;
#(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int CW = cnt_width(CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(CYCLES - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/game_progress_fsm.sv
// Game-progression controller: world/level/lives tracking, timed banners and a status code for HUD/audio.
// Everything visible is derived from registers; status_event flags the cycle after any status change.
module game_progress_fsm
    import game_pkg::*;
#(
    parameter  int NUM_WORLDS       = 2,
    parameter  int LEVELS_PER_WORLD = 6,
    parameter  int LIVES            = 3,
    parameter  int BANNER_CYCLES    = 4,
    localparam int LW               = cnt_width(LEVELS_PER_WORLD),
    localparam int WW               = cnt_width(NUM_WORLDS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               level_passed,
    input  logic               lose,
    output logic [LW-1:0]      level,
    output logic [WW-1:0]      world,
    output logic [LIVES_W-1:0] lives,
    output logic [2:0]         game_status,
    output logic               status_event
);

    localparam logic [LW-1:0]      LAST_LEVEL = LW'(LEVELS_PER_WORLD - 1);
    localparam logic [WW-1:0]      LAST_WORLD = WW'(NUM_WORLDS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_t               state;
    state_t               state_nxt;
    logic [LW-1:0]        level_nxt;
    logic [WW-1:0]        world_nxt;
    logic [LIVES_W-1:0]   lives_nxt;
    logic                 banner_load;
    logic                 banner_done;

    // Banners are only ever entered from PLAY, so entry is a non-banner to banner transition.
    assign banner_load = is_banner(state_nxt) && !is_banner(state);

    banner_timer #(
        .CYCLES (BANNER_CYCLES)
    ) u_banner_timer (
        .clk   (clk),
        .reset (reset),
        .load  (banner_load),
        .done  (banner_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            level        <= '0;
            world        <= '0;
            lives        <= LIVES_INIT;
            status_event <= 1'b0;
        end else begin
            state        <= state_nxt;
            level        <= level_nxt;
            world        <= world_nxt;
            lives        <= lives_nxt;
            status_event <= (state_nxt != state);
        end
    end

    always_comb begin
        state_nxt = state;
        level_nxt = level;
        world_nxt = world;
        lives_nxt = lives;
        case (state)
            ST_IDLE, ST_WIN_GAME, ST_GAME_OVER: begin
                if (start) begin
                    state_nxt = ST_PLAY;
                    level_nxt = '0;
                    world_nxt = '0;
                    lives_nxt = LIVES_INIT;
                end
            end
            ST_PLAY: begin
                if (level_passed) begin
                    if (level != LAST_LEVEL) begin
                        state_nxt = ST_WIN_LEVEL;
                        level_nxt = level + LW'(1);
                    end else if (world != LAST_WORLD) begin
                        state_nxt = ST_WIN_WORLD;
                        level_nxt = '0;
                        world_nxt = world + WW'(1);
                    end else begin
                        state_nxt = ST_WIN_GAME;
                    end
                end else if (lose) begin
                    if (lives > LIVES_W'(1)) begin
                        state_nxt = ST_LIFE_LOST;
                        lives_nxt = lives - LIVES_W'(1);
                    end else begin
                        state_nxt = ST_GAME_OVER;
                        lives_nxt = '0;
                    end
                end
            end
            ST_WIN_LEVEL, ST_WIN_WORLD, ST_LIFE_LOST: begin
                if (banner_done) begin
                    state_nxt = ST_PLAY;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        game_status = state_to_status(state);
    end

endmodule

// File: tb/tb_game_progress_fsm.sv
// Scenario tasks plus a randomized run against an abstract model of the game rules.
module tb_game_progress_fsm;

    localparam int NW  = 2;
    localparam int LPW = 3;
    localparam int LV  = 2;
    localparam int BC  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       level_passed = 1'b0;
    logic       lose = 1'b0;
    logic [1:0] level;
    logic [0:0] world;
    logic [3:0] lives;
    logic [2:0] game_status;
    logic       status_event;

    int vectors = 0;
    int miscompares = 0;

    // Abstract model: status code, counters, remaining banner cycles, change flag.
    int m_st, m_level, m_world, m_lives, m_rem;
    bit m_evt;

    always #5 clk = ~clk;

    game_progress_fsm #(
        .NUM_WORLDS       (NW),
        .LEVELS_PER_WORLD (LPW),
        .LIVES            (LV),
        .BANNER_CYCLES    (BC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .level_passed (level_passed),
        .lose         (lose),
        .level        (level),
        .world        (world),
        .lives        (lives),
        .game_status  (game_status),
        .status_event (status_event)
    );

    task automatic model_reset();
        m_st = 6; m_level = 0; m_world = 0; m_lives = LV; m_rem = 0; m_evt = 0;
    endtask

    task automatic model_step(input bit s, input bit lp, input bit ls);
        int prev;
        prev = m_st;
        if (m_st == 6 || m_st == 3 || m_st == 4) begin
            if (s) begin
                m_st = 0; m_level = 0; m_world = 0; m_lives = LV;
            end
        end else if (m_st == 0) begin
            if (lp) begin
                if (m_level < LPW - 1) begin
                    m_level++; m_st = 1; m_rem = BC;
                end else if (m_world < NW - 1) begin
                    m_level = 0; m_world++; m_st = 2; m_rem = BC;
                end else begin
                    m_st = 3;
                end
            end else if (ls) begin
                if (m_lives > 1) begin
                    m_lives--; m_st = 5; m_rem = BC;
                end else begin
                    m_lives = 0; m_st = 4;
                end
            end
        end else begin
            m_rem--;
            if (m_rem == 0) m_st = 0;
        end
        m_evt = (m_st != prev);
    endtask

    task automatic cyc(input bit s, input bit lp, input bit ls);
        @(negedge clk);
        start = s; level_passed = lp; lose = ls;
        @(posedge clk);
        model_step(s, lp, ls);
        #1;
    endtask

    task automatic wait_banner();
        repeat (BC) cyc(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; start = 0; level_passed = 0; lose = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        vectors++; if (game_status !== 3'd6) begin miscompares++; $display("FAIL reset_status got %0d exp 6", game_status); end
        vectors++; if (level !== 2'd0) begin miscompares++; $display("FAIL reset_level got %0d exp 0", level); end
        vectors++; if (world !== 1'd0) begin miscompares++; $display("FAIL reset_world got %0d exp 0", world); end
        vectors++; if (lives !== 4'd2) begin miscompares++; $display("FAIL reset_lives got %0d exp 2", lives); end
        vectors++; if (status_event !== 1'b0) begin miscompares++; $display("FAIL reset_event got %0d exp 0", status_event); end
        reset = 1'b1;
        cyc(0, 1, 1);
        vectors++; if (game_status !== 3'd6) begin miscompares++; $display("FAIL idle_ignores_play_inputs got %0d exp 6", game_status); end
    endtask

    task automatic test_start();
        cyc(1, 0, 0);
        vectors++; if (game_status !== 3'd0) begin miscompares++; $display("FAIL start_status got %0d exp 0", game_status); end
        vectors++; if (level !== 2'd0 || world !== 1'd0) begin miscompares++; $display("FAIL start_pos got %0d/%0d exp 0/0", world, level); end
        vectors++; if (lives !== 4'd2) begin miscompares++; $display("FAIL start_lives got %0d exp 2", lives); end
        vectors++; if (status_event !== 1'b1) begin miscompares++; $display("FAIL start_event got %0d exp 1", status_event); end
        cyc(0, 0, 0);
        vectors++; if (status_event !== 1'b0) begin miscompares++; $display("FAIL start_event_width got %0d exp 0", status_event); end
    endtask

    task automatic test_level_win();
        cyc(0, 1, 0);
        vectors++; if (game_status !== 3'd1 || level !== 2'd1) begin miscompares++; $display("FAIL win_level_entry got st %0d lvl %0d exp st 1 lvl 1", game_status, level); end
        vectors++; if (status_event !== 1'b1) begin miscompares++; $display("FAIL win_level_event got %0d exp 1", status_event); end
        for (int i = 1; i <= BC; i++) begin
            cyc(0, 0, 0);
            if (i < BC) begin
                vectors++; if (game_status !== 3'd1 || status_event !== 1'b0) begin miscompares++; $display("FAIL banner_hold_%0d got st %0d ev %0d exp st 1 ev 0", i, game_status, status_event); end
            end else begin
                vectors++; if (game_status !== 3'd0 || status_event !== 1'b1) begin miscompares++; $display("FAIL banner_exit got st %0d ev %0d exp st 0 ev 1", game_status, status_event); end
            end
        end
    endtask

    task automatic test_world_and_game();
        do_reset();
        cyc(1, 0, 0);
        repeat (2) begin cyc(0, 1, 0); wait_banner(); end
        cyc(0, 1, 0);
        vectors++; if (game_status !== 3'd2 || world !== 1'd1 || level !== 2'd0) begin miscompares++; $display("FAIL win_world got st %0d w %0d l %0d exp 2 1 0", game_status, world, level); end
        wait_banner();
        repeat (2) begin cyc(0, 1, 0); wait_banner(); end
        cyc(0, 1, 0);
        vectors++; if (game_status !== 3'd3 || world !== 1'd1 || level !== 2'd2) begin miscompares++; $display("FAIL win_game got st %0d w %0d l %0d exp 3 1 2", game_status, world, level); end
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            vectors++; if (game_status !== 3'd3 || status_event !== 1'b0 || level !== 2'd2) begin miscompares++; $display("FAIL win_game_hold_%0d got st %0d ev %0d l %0d exp 3 0 2", i, game_status, status_event, level); end
        end
        cyc(1, 0, 0);
        vectors++; if (game_status !== 3'd0 || world !== 1'd0 || level !== 2'd0 || lives !== 4'd2) begin miscompares++; $display("FAIL restart_after_win got st %0d w %0d l %0d lv %0d exp 0 0 0 2", game_status, world, level, lives); end
    endtask

    task automatic test_lose();
        cyc(0, 0, 1);
        vectors++; if (game_status !== 3'd5 || lives !== 4'd1) begin miscompares++; $display("FAIL life_lost got st %0d lv %0d exp 5 1", game_status, lives); end
        wait_banner();
        vectors++; if (game_status !== 3'd0) begin miscompares++; $display("FAIL life_lost_exit got %0d exp 0", game_status); end
        cyc(0, 0, 1);
        vectors++; if (game_status !== 3'd4 || lives !== 4'd0) begin miscompares++; $display("FAIL game_over got st %0d lv %0d exp 4 0", game_status, lives); end
        repeat (5) cyc(0, 1, 1);
        vectors++; if (game_status !== 3'd4 || lives !== 4'd0) begin miscompares++; $display("FAIL game_over_hold got st %0d lv %0d exp 4 0", game_status, lives); end
        cyc(1, 0, 0);
        vectors++; if (game_status !== 3'd0 || lives !== 4'd2 || level !== 2'd0 || world !== 1'd0) begin miscompares++; $display("FAIL restart_after_over got st %0d lv %0d exp 0 2", game_status, lives); end
    endtask

    task automatic test_priority();
        cyc(0, 1, 0);
        wait_banner();
        cyc(0, 1, 1);
        vectors++; if (game_status !== 3'd1 || level !== 2'd2 || lives !== 4'd2) begin miscompares++; $display("FAIL pass_beats_lose got st %0d l %0d lv %0d exp 1 2 2", game_status, level, lives); end
        for (int i = 1; i <= BC; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            vectors++; if (game_status !== ((i < BC) ? 3'd1 : 3'd0) || level !== 2'd2 || lives !== 4'd2) begin miscompares++; $display("FAIL banner_ignores_%0d got st %0d l %0d lv %0d", i, game_status, level, lives); end
        end
    endtask

    task automatic test_reset_mid_banner();
        int seen;
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        vectors++; if (game_status !== 3'd6 || level !== 2'd0 || world !== 1'd0 || lives !== 4'd2 || status_event !== 1'b0) begin miscompares++; $display("FAIL async_reset got st %0d l %0d w %0d lv %0d ev %0d", game_status, level, world, lives, status_event); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc(1, 0, 0);
        vectors++; if (game_status !== 3'd0 || status_event !== 1'b1 || lives !== 4'd2) begin miscompares++; $display("FAIL start_after_reset got st %0d ev %0d lv %0d exp 0 1 2", game_status, status_event, lives); end
        cyc(0, 1, 0);
        seen = (game_status == 3'd1) ? 1 : 0;
        for (int i = 0; i < BC + 2; i++) begin
            cyc(0, 0, 0);
            if (game_status == 3'd1) seen++;
        end
        vectors++; if (seen !== BC) begin miscompares++; $display("FAIL banner_len_after_reset got %0d exp %0d", seen, BC); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            vectors++;
            if (32'(game_status) !== m_st || 32'(level) !== m_level || 32'(world) !== m_world ||
                32'(lives) !== m_lives || status_event !== m_evt) begin
                miscompares++;
                $display("FAIL random_%0d got st %0d l %0d w %0d lv %0d ev %0d exp st %0d l %0d w %0d lv %0d ev %0d",
                         i, game_status, level, world, lives, status_event, m_st, m_level, m_world, m_lives, m_evt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_level_win();
        test_world_and_game();
        test_lose();
        test_priority();
        test_reset_mid_banner();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
